// File: rtl/tb_literal_loader_pkg.sv
// rtl/tb_literal_loader_pkg.sv - shared literal layout, loader states and packed-slice offsets
package tb_literal_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } tbl_state_e;

  // Literal = {polarity, address}; polarity sits just above the address field.
  localparam int LIT_ADDR_LSB = 0;
  localparam int NULL_ADDR    = 0;

  function automatic int lit_width(input int law);
    return law + 1;
  endfunction

  function automatic int lit_pol_bit(input int law);
    return law;
  endfunction

  // Offset of membership slot `slot` inside a packed literals_multi word.
  function automatic int slice_offset(input int slot, input int nsat, input int law);
    return slot * (nsat - 1) * (law + 1);
  endfunction

endpackage

// File: rtl/tb_literal_strip.sv
// rtl/tb_literal_strip.sv - drops the candidate's own literal from a clause and compacts the rest
module tb_literal_strip
  import tb_literal_loader_pkg::*;
#(
  parameter int NSAT = 3,
  parameter int LAW  = 11
) (
  input  logic [NSAT*(LAW+1)-1:0]     clause_i,
  input  logic [LAW-1:0]              cand_i,
  output logic [(NSAT-1)*(LAW+1)-1:0] lits_o,
  output logic                        miss_o
);

  localparam int LW = lit_width(LAW);

  int   drop_idx;
  logic found;

  // With no match the last literal is dropped so the slot is still NSAT-1 wide.
  always_comb begin
    found    = 1'b0;
    drop_idx = NSAT - 1;
    for (int k = 0; k < NSAT; k++) begin
      if (!found && clause_i[k*LW+LIT_ADDR_LSB +: LAW] == cand_i) begin
        found    = 1'b1;
        drop_idx = k;
      end
    end
    lits_o = '0;
    for (int j = 0; j < NSAT - 1; j++) begin
      lits_o[j*LW +: LW] = (j < drop_idx) ? clause_i[j*LW +: LW] : clause_i[(j+1)*LW +: LW];
    end
    miss_o = !found;
  end

endmodule

// File: rtl/tb_literal_loader.sv
// rtl/tb_literal_loader.sv - per-flip temporal buffer write producer; define TBL_EARLY_TERMINATE_EN
// to end a variable scan at its first empty membership slot.
module tb_literal_loader
  import tb_literal_loader_pkg::*;
#(
  parameter int NSAT                   = 3,
  parameter int VARIABLE_ADDRESS_WIDTH = 11,
  parameter int MAX_CLAUSE_MEMBERSHIP  = 20
) (
  input  logic                                                           clk,
  input  logic                                                           reset,
  input  logic                                                           start_i,
  input  logic [NSAT*VARIABLE_ADDRESS_WIDTH-1:0]                         cand_vars_i,
  output logic                                                           ct_req_o,
  output logic [VARIABLE_ADDRESS_WIDTH+$clog2(MAX_CLAUSE_MEMBERSHIP)-1:0] ct_addr_o,
  input  logic                                                           ct_ack_i,
  input  logic                                                           ct_valid_i,
  input  logic [NSAT*(VARIABLE_ADDRESS_WIDTH+1)-1:0]                     ct_clause_i,
  output logic [$clog2(NSAT)-1:0]                                        write_index_o,
  output logic                                                           write_en_o,
  output logic [(NSAT-1)*MAX_CLAUSE_MEMBERSHIP*(VARIABLE_ADDRESS_WIDTH+1)-1:0] literals_multi_o,
  output logic                                                           busy_o,
  output logic                                                           done_o,
  output logic                                                           err_o
);

  localparam int LAW    = VARIABLE_ADDRESS_WIDTH;
  localparam int MC     = MAX_CLAUSE_MEMBERSHIP;
  localparam int SW     = $clog2(MC);
  localparam int IW     = $clog2(NSAT);
  localparam int SLOT_W = (NSAT - 1) * lit_width(LAW);
  localparam int ACC_W  = SLOT_W * MC;
  localparam logic [SW-1:0] SLOT_LAST = SW'(MC - 1);
  localparam logic [IW-1:0] FLIP_LAST = IW'(NSAT - 1);

`ifdef TBL_EARLY_TERMINATE_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  tbl_state_e             state_q;
  logic [NSAT*LAW-1:0]    cand_q;
  logic [IW-1:0]          flip_q;
  logic [SW-1:0]          slot_q;
  logic [ACC_W-1:0]       acc_q;
  logic                   ct_req_q;
  logic                   write_en_q;
  logic [IW-1:0]          write_index_q;
  logic [ACC_W-1:0]       lits_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic [LAW-1:0]         cur_cand;
  logic [SLOT_W-1:0]      strip_lits;
  logic                   strip_miss;

  assign cur_cand = cand_q[int'(flip_q)*LAW +: LAW];

  tb_literal_strip #(
    .NSAT (NSAT),
    .LAW  (LAW)
  ) u_strip (
    .clause_i (ct_clause_i),
    .cand_i   (cur_cand),
    .lits_o   (strip_lits),
    .miss_o   (strip_miss)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cand_q        <= '0;
      flip_q        <= '0;
      slot_q        <= '0;
      acc_q         <= '0;
      ct_req_q      <= 1'b0;
      write_en_q    <= 1'b0;
      write_index_q <= '0;
      lits_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      write_en_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= start_i;
          if (start_i) begin
            cand_q   <= cand_vars_i;
            flip_q   <= '0;
            slot_q   <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            ct_req_q <= 1'b1;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ct_ack_i) begin
            acc_q[slice_offset(int'(slot_q), NSAT, LAW) +: SLOT_W] <= ct_valid_i ? strip_lits : '0;
            if (ct_valid_i && strip_miss) err_q <= 1'b1;
            // Membership lists are packed, so an empty slot means the rest are empty too.
            if (slot_q == SLOT_LAST || (EARLY_TERM && !ct_valid_i)) begin
              ct_req_q <= 1'b0;
              state_q  <= ST_WRITE;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          write_en_q    <= 1'b1;
          write_index_q <= flip_q;
          lits_q        <= acc_q;
          if (flip_q == FLIP_LAST) begin
            state_q <= ST_DONE;
          end else begin
            flip_q   <= flip_q + 1'b1;
            slot_q   <= '0;
            acc_q    <= '0;
            ct_req_q <= 1'b1;
            state_q  <= ST_REQ;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ct_req_o         = ct_req_q;
  assign ct_addr_o        = {cur_cand, slot_q};
  assign write_en_o       = write_en_q;
  assign write_index_o    = write_index_q;
  assign literals_multi_o = lits_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_tb_literal_loader.sv
// tb/tb_tb_literal_loader.sv - scoreboard bench for tb_literal_loader (NSAT=3, LAW=4, MC=2);
// honours TBL_EARLY_TERMINATE_EN for expected request counts.
module tb_tb_literal_loader;

  localparam int NSAT = 3;
  localparam int LAW  = 4;
  localparam int MC   = 2;

`ifdef TBL_EARLY_TERMINATE_EN
  localparam int ACKS_DUP = 4;
`else
  localparam int ACKS_DUP = 6;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [11:0] cand_vars_i = '0;
  logic        ct_req_o;
  logic [4:0]  ct_addr_o;
  logic        ct_ack_i = 1'b0;
  logic        ct_valid_i = 1'b0;
  logic [14:0] ct_clause_i = '0;
  logic [1:0]  write_index_o;
  logic        write_en_o;
  logic [19:0] literals_multi_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  tb_literal_loader #(
    .NSAT                   (NSAT),
    .VARIABLE_ADDRESS_WIDTH (LAW),
    .MAX_CLAUSE_MEMBERSHIP  (MC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .cand_vars_i      (cand_vars_i),
    .ct_req_o         (ct_req_o),
    .ct_addr_o        (ct_addr_o),
    .ct_ack_i         (ct_ack_i),
    .ct_valid_i       (ct_valid_i),
    .ct_clause_i      (ct_clause_i),
    .write_index_o    (write_index_o),
    .write_en_o       (write_en_o),
    .literals_multi_o (literals_multi_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o)
  );

  typedef struct packed {
    logic        is_done;
    logic [1:0]  idx;
    logic [19:0] lits;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [14:0] tbl_clause [32];
  logic        tbl_valid  [32];
  int          max_stall = 0;
  int          in_stall = 0;
  int          stall_left = 0;
  int          acks = 0;
  int          writes = 0;
  logic [4:0]  hold_addr = '0;
  logic        prev_we = 1'b0;
  logic [1:0]  prev_idx = '0;

  function automatic logic [4:0] lit(input logic p, input logic [3:0] a);
    return {p, a};
  endfunction

  function automatic logic [14:0] cl(input logic [4:0] l0, l1, l2);
    return {l2, l1, l0};
  endfunction

  function automatic logic [19:0] pk(input logic [4:0] s0a, s0b, s1a, s1b);
    return {s1b, s1a, s0b, s0a};
  endfunction

  function automatic logic [11:0] cands(input logic [3:0] c0, c1, c2);
    return {c2, c1, c0};
  endfunction

  function automatic exp_t wr(input logic [1:0] idx, input logic [19:0] lits);
    return '{is_done: 1'b0, idx: idx, lits: lits};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clause-table responder with optional random stalls.
  always @(negedge clk) begin
    ct_ack_i    = 1'b0;
    ct_valid_i  = 1'b0;
    ct_clause_i = '0;
    if (reset) begin
      in_stall = 0;
    end else if (in_stall != 0 || ct_req_o) begin
      if (in_stall != 0) begin
        chk("req_addr_stable", {ct_req_o, ct_addr_o}, {1'b1, hold_addr});
      end else begin
        hold_addr  = ct_addr_o;
        stall_left = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        in_stall   = 1;
      end
      if (stall_left == 0) begin
        ct_ack_i    = 1'b1;
        ct_valid_i  = tbl_valid[hold_addr];
        ct_clause_i = tbl_clause[hold_addr];
        in_stall    = 0;
        acks++;
      end else begin
        stall_left--;
      end
    end
  end

  // Monitor: pops the scoreboard on every write strobe and done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (write_en_o) begin
        writes++;
        if (sb.size() == 0 || sb[0].is_done) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: idx=%0d lits=%0h, no write expected", write_index_o, literals_multi_o);
        end else begin
          mon_e = sb.pop_front();
          chk("write_index", {30'd0, write_index_o}, {30'd0, mon_e.idx});
          chk("write_lits", {12'd0, literals_multi_o}, {12'd0, mon_e.lits});
        end
      end
      if (done_o) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=1, expected a write or nothing");
        end else begin
          mon_e = sb.pop_front();
          chk("done_follows_last_write", {29'd0, prev_we, prev_idx}, {29'd0, 1'b1, 2'd2});
        end
      end
    end
    prev_we  = write_en_o;
    prev_idx = write_index_o;
  end

  task automatic push_round(input exp_t e0, input exp_t e1, input exp_t e2);
    sb.push_back(e0);
    sb.push_back(e1);
    sb.push_back(e2);
    sb.push_back('{is_done: 1'b1, idx: 2'd0, lits: 20'd0});
  endtask

  task automatic run_round(input string tag, input logic [11:0] cv, input exp_t e0, input exp_t e1,
                           input exp_t e2, input logic exp_err, input int exp_acks, input int noisy);
    int n;
    push_round(e0, e1, e2);
    acks        = 0;
    cand_vars_i = cv;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, "_busy_after_start"}, {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < noisy; i++) begin
      start_i     = (i % 2 == 0);
      cand_vars_i = cands(4'd9, 4'd9, 4'd9);
      @(negedge clk);
    end
    start_i = 1'b0;
    n = 0;
    while (!done_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done_o}, 32'd1);
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    @(negedge clk);
    chk({tag, "_busy_cleared"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_ack_count"}, acks, exp_acks);
    repeat (3) @(negedge clk);
    chk({tag, "_scoreboard_empty"}, sb.size(), 32'd0);
  endtask

  exp_t b0, b1, b2;
  int   n, w_before;

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl_clause[i] = '0;
      tbl_valid[i]  = 1'b0;
    end
    // index = {var, slot}
    tbl_clause[6]  = cl(lit(0, 3), lit(1, 8), lit(0, 9));   tbl_valid[6]  = 1'b1;
    tbl_clause[7]  = cl(lit(0, 2), lit(1, 3), lit(0, 4));   tbl_valid[7]  = 1'b1;
    tbl_clause[10] = cl(lit(0, 6), lit(0, 10), lit(0, 5));  tbl_valid[10] = 1'b1;
    tbl_clause[11] = cl(lit(1, 5), lit(1, 1), lit(1, 12));  tbl_valid[11] = 1'b1;
    tbl_clause[14] = cl(lit(0, 7), lit(0, 7), lit(0, 11));  tbl_valid[14] = 1'b1;
    tbl_clause[26] = cl(lit(0, 4), lit(0, 6), lit(0, 9));   tbl_valid[26] = 1'b1;
    tbl_clause[27] = cl(lit(0, 13), lit(1, 1), lit(0, 0));  tbl_valid[27] = 1'b1;

    b0 = wr(2'd0, pk(lit(1, 8), lit(0, 9), lit(0, 2), lit(0, 4)));
    b1 = wr(2'd1, pk(lit(0, 6), lit(0, 10), lit(1, 1), lit(1, 12)));
    b2 = wr(2'd2, pk(lit(0, 7), lit(0, 11), 5'd0, 5'd0));

    repeat (3) @(negedge clk);
    chk("reset_outputs", {ct_req_o, ct_addr_o, write_index_o, write_en_o, busy_o, done_o, err_o}, 32'd0);
    chk("reset_lits", {12'd0, literals_multi_o}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_round("basic", cands(4'd3, 4'd5, 4'd7), b0, b1, b2, 1'b0, 6, 0);

    max_stall = 4;
    run_round("stall", cands(4'd3, 4'd5, 4'd7), b0, b1, b2, 1'b0, 6, 0);
    max_stall = 0;

    run_round("dup_invalid", cands(4'd9, 4'd9, 4'd7), wr(2'd0, 20'd0), wr(2'd1, 20'd0), b2, 1'b0, ACKS_DUP, 0);

    run_round("miss", cands(4'd13, 4'd3, 4'd5),
              wr(2'd0, pk(lit(0, 4), lit(0, 6), lit(1, 1), 5'd0)),
              wr(2'd1, b0.lits), wr(2'd2, b1.lits), 1'b1, 6, 0);
    repeat (2) @(negedge clk);
    chk("err_sticky_idle", {31'd0, err_o}, 32'd1);

    // Reset while requesting for flip 1.
    push_round(b0, b1, b2);
    cand_vars_i = cands(4'd3, 4'd5, 4'd7);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("err_cleared_on_start", {31'd0, err_o}, 32'd0);
    n = 0;
    while (!(ct_req_o && ct_addr_o[4:1] == 4'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_flip1", {27'd0, ct_req_o, ct_addr_o[4:1]}, {27'd0, 1'b1, 4'd5});
    reset = 1'b1;
    sb.delete();
    w_before = writes;
    @(negedge clk);
    chk("midround_reset_outputs", {ct_req_o, ct_addr_o, write_index_o, write_en_o, busy_o, done_o, err_o}, 32'd0);
    chk("midround_reset_lits", {12'd0, literals_multi_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_write_after_reset", writes, w_before);

    run_round("after_reset", cands(4'd3, 4'd5, 4'd7), b0, b1, b2, 1'b0, 6, 0);

    run_round("start_while_busy", cands(4'd3, 4'd5, 4'd7), b0, b1, b2, 1'b0, 6, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tb_literal_loader.md
Name: tb_literal_loader

Overview:
- Write-side producer for the per-flip temporal buffer bank.
- On start, walks the NSAT candidate variables of the selected unsatisfied clause. For each one it fetches every clause-table entry the variable belongs to, strips the candidate's own literal, and packs the NSAT-1 remaining literals per membership slot.
- Issues one buffer write per candidate flip, with write index = candidate position.
- Sits between the clause-table read port and the temporal buffer bank's write port.

Parameters:
- NSAT, 3, literals per clause / candidate flips per round.
- VARIABLE_ADDRESS_WIDTH, 11, variable address width (LAW). Literal = {polarity bit, LAW-bit address}; address 0 is the null literal.
- MAX_CLAUSE_MEMBERSHIP, 20, membership slots per variable (MC).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  begin a round; sampled in IDLE only
- cand_vars_i  in  NSAT*LAW  candidate variable addresses; slot k = bits [k*LAW +: LAW]; captured on accepted start
- ct_req_o  out  1  clause-table read request
- ct_addr_o  out  LAW+$clog2(MC)  {variable, slot}
- ct_ack_i  in  1  read data valid; completes the request
- ct_valid_i  in  1  slot holds a real clause (qualified by ct_ack_i)
- ct_clause_i  in  NSAT*(LAW+1)  clause literals
- write_index_o  out  $clog2(NSAT)  flip index for the buffer
- write_en_o  out  1  one-cycle buffer write strobe
- literals_multi_o  out  (NSAT-1)*MC*(LAW+1)  packed literals; slot s at [s*(NSAT-1)*(LAW+1) +: (NSAT-1)*(LAW+1)]
- busy_o  out  1  round in progress
- done_o  out  1  one-cycle pulse after the last write
- err_o  out  1  sticky; candidate literal missing from a valid clause

Behaviour:
- Reset:
  - All outputs 0; state IDLE; counters and the literal accumulator cleared.
  - Reset mid-round aborts immediately; no further write_en_o.
- States and transitions:
  - IDLE: start_i=1 → capture cand_vars_i; flip=0, slot=0; clear accumulator; go to REQ. busy_o=1 from the next cycle.
  - REQ: ct_req_o=1 and ct_addr_o={cand[flip], slot} held stable until ct_ack_i. On ack:
    - Store the processed result into accumulator slot `slot`.
    - slot==MC-1 → WRITE; else slot+1, stay in REQ.
    - Request may stay high across back-to-back slots, one per ack.
  - WRITE: write_en_o=1 for exactly one cycle; write_index_o=flip; literals_multi_o=accumulator.
    - flip==NSAT-1 → DONE.
    - Otherwise flip+1, slot=0, clear accumulator, go to REQ.
  - DONE: done_o=1 for one cycle; busy_o=0 next cycle; go to IDLE.
- Processing an acked clause:
  - ct_valid_i=0 → slot stored as all zeros.
  - ct_valid_i=1 → drop the first literal whose address equals cand[flip]. Compact the remaining literals in ascending original order into positions 0..NSAT-2.
  - No match → drop literal NSAT-1 and set err_o. err_o clears only on reset or on an accepted start.
- Timing and boundaries:
  - write_index_o and literals_multi_o are registered and held stable from WRITE until the next WRITE.
  - Minimum latency per flip = MC ack cycles + 1 write cycle.
  - start_i is ignored while busy.
  - ct_ack_i outside REQ is ignored.
  - A duplicate candidate address is legal and yields identical buffer contents.

Optional Feature:
- Macro TBL_EARLY_TERMINATE_EN.
- Defined:
  - An ack with ct_valid_i=0 ends the scan of the current variable and goes straight to WRITE. Membership lists are packed, so every later slot stays zero.
  - Saves cycles for variables with few memberships.
- Undefined:
  - All MC slots are always requested.
- Buffer contents are identical either way; only cycle counts differ.

Decomposition:
- Shared package:
  - Literal width LAW+1, literal polarity/address field positions, null-literal constant.
  - State encoding (IDLE/REQ/WRITE/DONE).
  - Packed-slice offset function, shared with the temporal buffer bank.
- Natural sub-module: tb_literal_strip, combinational. Takes clause + candidate address; returns the NSAT-1 compacted literals + miss flag.

Test Plan:
- Basic round, NSAT=3, LAW=4, MC=2, cand={3,5,7}, all acks immediate, clauses contain the candidates → three writes with indices 0,1,2. Per-slot literals are the two non-candidate literals in order; done_o one cycle after the third write; err_o=0.
- Ack stalls of 0–4 random cycles → ct_addr_o and ct_req_o stable throughout each stall; buffer data identical to the no-stall run.
- Slot with ct_valid_i=0 → that slot is zero in literals_multi_o. With TBL_EARLY_TERMINATE_EN: the write follows that ack directly and later slots are never requested.
- Valid clause lacking the candidate, e.g. cand=3, clause {4,6,9} → literals {4,6} stored, err_o=1 until the next start.
- Reset asserted in REQ of flip 1 → the next cycle has all outputs 0 and no write_en_o. A fresh start then runs a clean full round.
- start_i pulsed while busy → ignored; exactly NSAT writes and one done_o.
